draw_engine: RTL and testbench

DRAW_ENGINE -- requirements
Module: draw_engine

---
 rtl/draw_engine.sv | 194 +++++++++++++++++++
 tb/tb_draw_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_engine.sv
// draw_engine: pixel sequencer for a 160x120 VGA adapter. Streams one pixel
// per cycle for full-screen fills (background, win screen) and for the
// CAR_W x CAR_H car rectangle (draw or erase), then holds a per-command
// done flag until the command is released.
// Optional feature: define DRAW_ENGINE_CLIP_EN to suppress plotting of car
// pixels that fall off-screen; otherwise car pixels wrap around the screen.
module draw_engine #(
  parameter int unsigned CAR_W      = 8,
  parameter int unsigned CAR_H      = 4,
  parameter logic [2:0]  CAR_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw_background,
  input  logic       erase_car,
  input  logic       draw_car,
  input  logic       draw_win_screen,
  input  logic [7:0] car_x,
  input  logic [6:0] car_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done_background,
  output logic       done_erase,
  output logic       done_car,
  output logic       done_win
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] SCR_W      = 9'd160;
  localparam logic [CNT_W-1:0] SCR_H      = 9'd120;
  localparam logic [CNT_W-1:0] TRACK_TOP  = 9'd52;
  localparam logic [CNT_W-1:0] TRACK_BOT  = 9'd67;
  localparam logic [CNT_W-1:0] CAR_LAST_X = 9'(CAR_W - 1);
  localparam logic [CNT_W-1:0] CAR_LAST_Y = 9'(CAR_H - 1);
  localparam logic [2:0] COL_GRASS = 3'b010;
  localparam logic [2:0] COL_TRACK = 3'b000;
  localparam logic [2:0] COL_WIN   = 3'b110;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  typedef enum logic [1:0] {CMD_BG, CMD_ERASE, CMD_CAR, CMD_WIN} cmd_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
  } pix_t;

  state_t           state;
  cmd_t             cmd;
  logic [CNT_W-1:0] base_x, base_y;
  logic [CNT_W-1:0] off_x, off_y;
  logic [3:0]       done_q;

  cmd_t             sel_cmd;
  logic             any_cmd;
  logic             cmd_held;
  logic [CNT_W-1:0] last_x, last_y;
  logic             at_row_end, at_last;
  logic [CNT_W-1:0] nxt_off_x, nxt_off_y;
  logic [CNT_W-1:0] sel_base_x, sel_base_y;
  pix_t             start_pix, step_pix;

  function automatic logic is_full(input cmd_t c);
    return (c == CMD_BG) || (c == CMD_WIN);
  endfunction

  // Map an absolute 9-bit coordinate to an output pixel for command c.
  function automatic pix_t make_pix(input cmd_t c, input logic [CNT_W-1:0] px,
                                    input logic [CNT_W-1:0] py);
    pix_t             p;
    logic [CNT_W-1:0] ex, ey;
    ex     = px;
    ey     = py;
    p.plot = 1'b1;
    if (!is_full(c)) begin
`ifdef DRAW_ENGINE_CLIP_EN
      p.plot = (px < SCR_W) && (py < SCR_H);
`else
      // Car sums never reach twice the screen size, so one subtraction wraps.
      if (px >= SCR_W) ex = px - SCR_W;
      if (py >= SCR_H) ey = py - SCR_H;
`endif
    end
    p.x = ex[7:0];
    p.y = ey[6:0];
    case (c)
      CMD_WIN: p.colour = COL_WIN;
      CMD_CAR: p.colour = CAR_COLOUR;
      default: p.colour = (ey >= TRACK_TOP && ey <= TRACK_BOT) ? COL_TRACK : COL_GRASS;
    endcase
    return p;
  endfunction

  // Fixed-priority selection of the command to accept from IDLE.
  always_comb begin
    sel_cmd = CMD_CAR;
    if (draw_win_screen)      sel_cmd = CMD_WIN;
    else if (draw_background) sel_cmd = CMD_BG;
    else if (erase_car)       sel_cmd = CMD_ERASE;
  end

  assign any_cmd = draw_win_screen | draw_background | erase_car | draw_car;

  // Level of the command currently being serviced.
  always_comb begin
    cmd_held = 1'b0;
    case (cmd)
      CMD_BG:    cmd_held = draw_background;
      CMD_ERASE: cmd_held = erase_car;
      CMD_CAR:   cmd_held = draw_car;
      CMD_WIN:   cmd_held = draw_win_screen;
      default:   cmd_held = 1'b0;
    endcase
  end

  // Raster stepping of the offset counters within the active extent.
  always_comb begin
    last_x     = is_full(cmd) ? (SCR_W - 9'd1) : CAR_LAST_X;
    last_y     = is_full(cmd) ? (SCR_H - 9'd1) : CAR_LAST_Y;
    at_row_end = (off_x == last_x);
    at_last    = at_row_end && (off_y == last_y);
    nxt_off_x  = at_row_end ? '0 : off_x + 9'd1;
    nxt_off_y  = at_row_end ? off_y + 9'd1 : off_y;
    sel_base_x = is_full(sel_cmd) ? '0 : {1'b0, car_x};
    sel_base_y = is_full(sel_cmd) ? '0 : {2'b00, car_y};
    start_pix  = make_pix(sel_cmd, sel_base_x, sel_base_y);
    step_pix   = make_pix(cmd, base_x + nxt_off_x, base_y + nxt_off_y);
  end

  // Control FSM with registered pixel and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cmd                   <= CMD_BG;
      base_x                <= '0;
      base_y                <= '0;
      off_x                 <= '0;
      off_y                 <= '0;
      {x, y, colour, plot}  <= '0;
      done_q                <= '0;
    end else begin
      case (state)
        IDLE: begin
          plot   <= 1'b0;
          done_q <= '0;
          if (any_cmd) begin
            cmd                  <= sel_cmd;
            base_x               <= sel_base_x;
            base_y               <= sel_base_y;
            off_x                <= '0;
            off_y                <= '0;
            {x, y, colour, plot} <= start_pix;
            state                <= DRAW;
          end
        end
        DRAW: begin
          if (!cmd_held) begin
            plot  <= 1'b0;
            state <= IDLE;
          end else if (at_last) begin
            plot   <= 1'b0;
            done_q <= 4'b0001 << cmd;
            state  <= DONE;
          end else begin
            off_x                <= nxt_off_x;
            off_y                <= nxt_off_y;
            {x, y, colour, plot} <= step_pix;
          end
        end
        DONE: begin
          plot <= 1'b0;
          if (!cmd_held) begin
            done_q <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          plot   <= 1'b0;
          done_q <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign done_background = done_q[0];
  assign done_erase      = done_q[1];
  assign done_car        = done_q[2];
  assign done_win        = done_q[3];

endmodule

// File: tb/tb_draw_engine.sv
// tb_draw_engine: vector table, corner-case sequences and randomized car
// draws checked against a pixel-list reference model of the draw engine.
module tb_draw_engine;

  localparam int CW = 8;
  localparam int CH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       draw_background, erase_car, draw_car, draw_win_screen;
  logic [7:0] car_x;
  logic [6:0] car_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done_background, done_erase, done_car, done_win;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  // id: 0 background, 1 erase, 2 car, 3 win
  typedef struct {
    int id;
    int cx;
    int cy;
    int cycles;
    int plots;
    int fx;
    int fy;
    int fc;
    int lx;
    int ly;
  } vec_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   exp_cycles;

  draw_engine dut (
    .clk(clk), .rst(rst),
    .draw_background(draw_background), .erase_car(erase_car),
    .draw_car(draw_car), .draw_win_screen(draw_win_screen),
    .car_x(car_x), .car_y(car_y),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .done_background(done_background), .done_erase(done_erase),
    .done_car(done_car), .done_win(done_win)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int done_vec();
    return int'({done_win, done_car, done_erase, done_background});
  endfunction

  task automatic set_cmd(input int id, input logic v);
    case (id)
      0: draw_background = v;
      1: erase_car       = v;
      2: draw_car        = v;
      default: draw_win_screen = v;
    endcase
  endtask

  function automatic logic [2:0] bg_col(input int yy);
    return (yy >= 52 && yy <= 67) ? 3'b000 : 3'b010;
  endfunction

  // Reference: list of plotted pixels and number of drawing cycles.
  function automatic void build_model(input int id, input int cx, input int cy);
    pix_t p;
    exp_q.delete();
    if (id == 0 || id == 3) begin
      exp_cycles = 160 * 120;
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) begin
          p.x = 8'(xx); p.y = 7'(yy);
          p.c = (id == 3) ? 3'b110 : bg_col(yy);
          exp_q.push_back(p);
        end
    end else begin
      exp_cycles = CW * CH;
      for (int dy = 0; dy < CH; dy++)
        for (int dx = 0; dx < CW; dx++) begin
          int px, py;
          px = cx + dx;
          py = cy + dy;
`ifdef DRAW_ENGINE_CLIP_EN
          if (px < 160 && py < 120) begin
            p.x = 8'(px); p.y = 7'(py);
            p.c = (id == 2) ? 3'b100 : bg_col(py);
            exp_q.push_back(p);
          end
`else
          px = px % 160;
          py = py % 120;
          p.x = 8'(px); p.y = 7'(py);
          p.c = (id == 2) ? 3'b100 : bg_col(py);
          exp_q.push_back(p);
`endif
        end
    end
  endfunction

  // From the acceptance edge: collect pixels until done, then release.
  task automatic capture(input int id, input string name, output int cycles);
    pix_t p;
    bit   fin;
    @(posedge clk);
    #1;
    car_x = 8'($urandom);
    car_y = 7'($urandom);
    got_q.delete();
    cycles = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (done_vec() != 0 || cycles > 19300) fin = 1'b1;
      else begin
        if (plot) begin
          p.x = x; p.y = y; p.c = colour;
          got_q.push_back(p);
        end
        cycles++;
      end
    end
    check($sformatf("%s done flag", name), done_vec(), 1 << id);
    check($sformatf("%s plot in done", name), int'(plot), 0);
    repeat (2) @(negedge clk);
    check($sformatf("%s done held", name), done_vec(), 1 << id);
    @(posedge clk);
    #1;
    set_cmd(id, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s done cleared", name), done_vec(), 0);
  endtask

  task automatic run(input int id, input int cx, input int cy, input int also,
                     input string name, output int cycles);
    @(posedge clk);
    #1;
    car_x = 8'(cx);
    car_y = 7'(cy);
    set_cmd(id, 1'b1);
    if (also >= 0) set_cmd(also, 1'b1);
    capture(id, name, cycles);
  endtask

  task automatic compare_model(input string name, input int cycles);
    int bad;
    bad = 0;
    check($sformatf("%s cycles", name), cycles, exp_cycles);
    check($sformatf("%s plot count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    check($sformatf("%s pixel mismatches", name), bad, 0);
  endtask

  vec_t vecs[7];
  int   cyc;
  int   n;
  int   guard;

  initial begin
    vecs[0] = '{2, 10, 20, 32, 32, 10, 20, 4, 17, 23};
    vecs[1] = '{1, 10, 50, 32, 32, 10, 50, 2, 17, 53};
    vecs[2] = '{1, 0, 60, 32, 32, 0, 60, 0, 7, 63};
    vecs[3] = '{2, 152, 0, 32, 32, 152, 0, 4, 159, 3};
`ifdef DRAW_ENGINE_CLIP_EN
    vecs[4] = '{2, 157, 118, 32, 6, 157, 118, 4, 159, 119};
`else
    vecs[4] = '{2, 157, 118, 32, 32, 157, 118, 4, 4, 1};
`endif
    vecs[5] = '{0, 0, 0, 19200, 19200, 0, 0, 2, 159, 119};
    vecs[6] = '{3, 0, 0, 19200, 19200, 0, 0, 6, 159, 119};

    rst = 1'b1;
    draw_background = 1'b0; erase_car = 1'b0; draw_car = 1'b0; draw_win_screen = 1'b0;
    car_x = '0; car_y = '0;
    #3;
    check("reset outputs", int'({x, y, colour, plot}), 0);
    check("reset done", done_vec(), 0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 7; i++) begin
      build_model(vecs[i].id, vecs[i].cx, vecs[i].cy);
      run(vecs[i].id, vecs[i].cx, vecs[i].cy, -1, $sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d cycles", i), cyc, vecs[i].cycles);
      check($sformatf("vec%0d plots", i), got_q.size(), vecs[i].plots);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d first x", i), int'(got_q[0].x), vecs[i].fx);
        check($sformatf("vec%0d first y", i), int'(got_q[0].y), vecs[i].fy);
        check($sformatf("vec%0d first colour", i), int'(got_q[0].c), vecs[i].fc);
        check($sformatf("vec%0d last x", i), int'(got_q[got_q.size()-1].x), vecs[i].lx);
        check($sformatf("vec%0d last y", i), int'(got_q[got_q.size()-1].y), vecs[i].ly);
      end else begin
        check($sformatf("vec%0d no pixels", i), 1, 0);
      end
      compare_model($sformatf("vec%0d model", i), cyc);
    end

    // Background and car together: background first, then car while held
    build_model(0, 0, 0);
    run(0, 10, 20, 2, "bg+car bg", cyc);
    compare_model("bg+car bg model", cyc);
    check("bg pixel (5,60) colour", int'(got_q[60*160+5].c), 0);
    check("bg pixel (5,10) colour", int'(got_q[10*160+5].c), 2);
    car_x = 8'd10;
    car_y = 7'd20;
    build_model(2, 10, 20);
    capture(2, "bg+car car", cyc);
    compare_model("bg+car car model", cyc);

    // Abort erase after five pixels
    @(posedge clk);
    #1;
    car_x = 8'd20; car_y = 7'd30; erase_car = 1'b1;
    @(posedge clk);
    n = 0; guard = 0;
    while (n < 5 && guard < 50) begin
      @(negedge clk);
      if (plot) n++;
      guard++;
    end
    check("abort pixels seen", n, 5);
    erase_car = 1'b0;
    @(negedge clk);
    check("abort plot low", int'(plot), 0);
    check("abort no done", done_vec(), 0);
    @(negedge clk);
    check("abort idle plot", int'(plot), 0);
    build_model(2, 50, 60);
    run(2, 50, 60, -1, "after abort", cyc);
    compare_model("after abort model", cyc);

    // Asynchronous reset in the middle of a car draw
    @(posedge clk);
    #1;
    car_x = 8'd30; car_y = 7'd40; draw_car = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("pre-reset plot", int'(plot), 1);
    rst = 1'b1;
    #1;
    check("async reset outputs", int'({x, y, colour, plot}), 0);
    check("async reset done", done_vec(), 0);
    draw_car = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset done", done_vec(), 0);
    check("post-reset plot", int'(plot), 0);
    build_model(2, 30, 40);
    run(2, 30, 40, -1, "after reset", cyc);
    compare_model("after reset model", cyc);

    // Randomized car draws and erases
    for (int i = 0; i < 24; i++) begin
      int id, cx, cy;
      id = int'($urandom_range(1, 2));
      cx = int'($urandom_range(0, 255));
      cy = int'($urandom_range(0, 127));
      build_model(id, cx, cy);
      run(id, cx, cy, -1, $sformatf("rand%0d", i), cyc);
      compare_model($sformatf("rand%0d model", i), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
